lcd_spi_master: RTL and testbench

//  Upstream SPI master for the LCD bridge. Accepts one LCD command (rs, rw, data byte) per handshake.

---
 rtl/lcd_bridge_pkg.sv | 39 +++
 rtl/lcd_spi_tick.sv | 34 +++
 rtl/lcd_spi_master.sv | 188 ++++++++++++++++++
 tb/tb_lcd_spi_master.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_bridge_pkg
// Brief    : Shared constants, FSM encoding and frame builder for the LCD bridge
// Revision : 1.0 - initial release
// ============================================================================
package lcd_bridge_pkg;

    localparam int   CTL_RS     = 1;
    localparam int   CTL_RW     = 0;
    localparam logic RW_WRITE   = 1'b1;
    localparam int   FRAME_BITS = 16;
    localparam int   CTL_BITS   = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HI    = 3'd2,
        ST_LO    = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } spi_state_t;

    // Control byte occupies the upper half so it goes out first, MSB first.
    function automatic logic [FRAME_BITS-1:0] make_frame(
        input logic       rs,
        input logic       rw,
        input logic [7:0] data
    );
        logic [FRAME_BITS-1:0] frame;
        frame                     = '0;
        frame[CTL_BITS + CTL_RS]  = rs;
        frame[CTL_BITS + CTL_RW]  = rw;
        frame[CTL_BITS-1:0]       = data;
        return frame;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_spi_tick.sv
`default_nettype none
// ============================================================================
// Module   : lcd_spi_tick
// Brief    : Loadable saturating down-counter; done while the count is zero
// Revision : 1.0 - initial release
// ============================================================================
module lcd_spi_tick #(
    parameter int WIDTH = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count = r_count;
    assign done  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/lcd_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : lcd_spi_master
// Brief    : 16-bit SPI master for the LCD bridge (ctl byte + data byte)
// Revision : 1.0 - initial release
// ============================================================================
module lcd_spi_master
    import lcd_bridge_pkg::*;
#(
    parameter int SCK_HALF   = 8,
    parameter int CS_SETUP   = 4,
    parameter int GAP_CYCLES = 16384
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rs,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       cs,
    output logic       sck,
    output logic       mosi,
    input  logic       miso
);

    localparam int c_MAX_A = (SCK_HALF > CS_SETUP) ? SCK_HALF : CS_SETUP;
    localparam int c_MAX   = (c_MAX_A > GAP_CYCLES) ? c_MAX_A : GAP_CYCLES;
    localparam int c_CNT_W = $clog2(c_MAX) + 1;
    localparam int c_BIT_W = $clog2(FRAME_BITS);

    localparam logic [c_CNT_W-1:0] c_LD_SETUP = c_CNT_W'(CS_SETUP - 1);
    localparam logic [c_CNT_W-1:0] c_LD_HALF  = c_CNT_W'(SCK_HALF - 1);
    localparam logic [c_CNT_W-1:0] c_LD_GAP   = c_CNT_W'(GAP_CYCLES - 1);
    // Down-counter value at LO cycle SCK_HALF/2 counted from state entry.
    localparam logic [c_CNT_W-1:0] c_SAMPLE   = c_CNT_W'(SCK_HALF - 1 - SCK_HALF / 2);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(FRAME_BITS - 1);
    localparam logic [c_BIT_W-1:0] c_RX_FIRST = c_BIT_W'(CTL_BITS);

    spi_state_t r_state;
    spi_state_t w_state_next;

    logic                  w_accept;
    logic                  w_shift_tx;
    logic                  w_sample;
    logic                  w_finish;
    logic                  w_tick_load;
    logic [c_CNT_W-1:0]    w_tick_val;
    logic [c_CNT_W-1:0]    w_tick_count;
    logic                  w_tick_done;
    logic [FRAME_BITS-1:0] w_frame;

    logic [FRAME_BITS-1:0] r_tx;
    logic [7:0]            r_rx;
    logic [c_BIT_W-1:0]    r_bit;
    logic                  r_miso_s1;
    logic                  r_miso_s2;

    assign w_frame = make_frame(cmd_rs, cmd_rw, cmd_data);

    lcd_spi_tick #(
        .WIDTH (c_CNT_W)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_tick_load),
        .load_val (w_tick_val),
        .count    (w_tick_count),
        .done     (w_tick_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_shift_tx   = 1'b0;
        w_sample     = 1'b0;
        w_finish     = 1'b0;
        w_tick_load  = 1'b0;
        w_tick_val   = c_LD_HALF;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_SETUP;
                    w_tick_load  = 1'b1;
                    w_tick_val   = c_LD_SETUP;
                end
            end
            ST_SETUP: begin
                if (w_tick_done) begin
                    w_state_next = ST_HI;
                    w_tick_load  = 1'b1;
                end
            end
            ST_HI: begin
                if (w_tick_done) begin
                    w_state_next = ST_LO;
                    w_tick_load  = 1'b1;
                end
            end
            ST_LO: begin
                w_sample = (r_bit >= c_RX_FIRST) && (w_tick_count == c_SAMPLE);
                if (w_tick_done) begin
                    w_tick_load = 1'b1;
                    if (r_bit != c_LAST_BIT) begin
                        w_shift_tx   = 1'b1;
                        w_state_next = ST_HI;
                    end else begin
                        w_state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (w_tick_done) begin
                    w_finish     = 1'b1;
                    w_state_next = ST_GAP;
                    w_tick_load  = 1'b1;
                    w_tick_val   = c_LD_GAP;
                end
            end
            ST_GAP: begin
                if (w_tick_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Pin outputs are registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs        <= 1'b1;
            sck       <= 1'b0;
            mosi      <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            busy      <= 1'b0;
            r_tx      <= '0;
            r_rx      <= 8'h00;
            r_bit     <= '0;
            r_miso_s1 <= 1'b0;
            r_miso_s2 <= 1'b0;
        end else begin
            r_miso_s1 <= miso;
            r_miso_s2 <= r_miso_s1;
            cmd_ready <= (w_state_next == ST_IDLE);
            busy      <= (w_state_next != ST_IDLE);
            sck       <= (w_state_next == ST_HI);
            cs        <= !(w_state_next inside {ST_SETUP, ST_HI, ST_LO, ST_HOLD});
            rsp_valid <= w_finish;
            if (w_accept) begin
                r_tx  <= w_frame;
                mosi  <= w_frame[FRAME_BITS-1];
                r_bit <= '0;
                r_rx  <= 8'h00;
            end
            if (w_shift_tx) begin
                r_tx  <= r_tx << 1;
                mosi  <= r_tx[FRAME_BITS-2];
                r_bit <= r_bit + 1'b1;
            end
            if (w_sample) begin
                r_rx <= {r_rx[6:0], r_miso_s2};
            end
            if (w_finish) begin
                rsp_data <= r_rx;
                mosi     <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_spi_master
// Brief    : Directed bench with bridge model and pin-level protocol checks
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_spi_master;

    localparam int SH     = 2;
    localparam int CSU    = 3;
    localparam int GAP    = 40;
    localparam int CS_LEN = CSU + 33 * SH;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_rs    = 1'b0;
    logic       cmd_rw    = 1'b0;
    logic [7:0] cmd_data  = 8'h00;
    logic       miso      = 1'b0;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       cs;
    logic       sck;
    logic       mosi;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lcd_spi_master #(
        .SCK_HALF   (SH),
        .CS_SETUP   (CSU),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rs    (cmd_rs),
        .cmd_rw    (cmd_rw),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .cs        (cs),
        .sck       (sck),
        .mosi      (mosi),
        .miso      (miso)
    );

    // Bridge model state
    logic        sck_p = 1'b0, cs_p = 1'b1, mosi_p = 1'b0;
    logic        chk_en = 1'b0;
    logic [15:0] sh_frame = '0, last_frame = '0;
    logic [7:0]  ret_byte = 8'h00, rd_at_rise = 8'h00;
    logic        rv_at_rise = 1'b0;
    int          bit_idx = 0, rises = 0, last_rises = 0, cs_len = 0, last_cs_len = 0;
    int          frame_cnt = 0, rv_cnt = 0, busy_ready = 0;
    int          cyc = 0, rise_cyc = 0, gap_len = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rsp_valid) rv_cnt++;
        if (busy && cmd_ready) busy_ready++;
        if (!cs && cs_p) begin
            bit_idx  = 0;
            rises    = 0;
            cs_len   = 0;
            sh_frame = '0;
            gap_len  = cyc - rise_cyc;
        end
        if (!cs) cs_len++;
        if (!cs && sck && !sck_p) begin
            rises++;
            miso = (bit_idx >= 8) ? ret_byte[3'(15 - bit_idx)] : 1'b0;
        end
        if (!cs && !sck && sck_p) begin
            sh_frame = {sh_frame[14:0], mosi};
            bit_idx++;
        end
        if (cs && !cs_p) begin
            last_frame  = sh_frame;
            last_rises  = rises;
            last_cs_len = cs_len;
            rv_at_rise  = rsp_valid;
            rd_at_rise  = rsp_data;
            rise_cyc    = cyc;
            frame_cnt++;
        end
        if (chk_en) begin
            if (sck && sck_p) begin
                n_cmp++;
                assert (mosi === mosi_p) else begin
                    n_err++;
                    $error("FAIL mosi_stable: observed %0b expected %0b", mosi, mosi_p);
                end
            end
            if (cs !== cs_p) begin
                n_cmp++;
                assert ((sck | sck_p) === 1'b0) else begin
                    n_err++;
                    $error("FAIL cs_edge_sck_low: observed sck %0b/%0b expected 0", sck_p, sck);
                end
            end
            if (cs) begin
                n_cmp++;
                assert (sck === 1'b0) else begin
                    n_err++;
                    $error("FAIL sck_idle_cs_high: observed %0b expected 0", sck);
                end
            end
        end
        sck_p  = sck;
        cs_p   = cs;
        mosi_p = mosi;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic rs, input logic rw, input logic [7:0] data);
        for (int i = 0; i < 300 && !cmd_ready; i++) @(negedge clk);
        chk("ready_wait", 32'(cmd_ready), 1);
        cmd_rs    = rs;
        cmd_rw    = rw;
        cmd_data  = data;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int target;
        target = frame_cnt + n;
        for (int i = 0; i < budget && frame_cnt < target; i++) @(posedge clk);
        #1;
        chk("frame_wait", 32'(frame_cnt >= target), 1);
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cs", 32'(cs), 1);
        chk("rst_sck", 32'(sck), 0);
        chk("rst_mosi", 32'(mosi), 0);
        chk("rst_ready", 32'(cmd_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 32'(cmd_ready), 1);
        chk("idle_busy", 32'(busy), 0);
        chk_en = 1'b1;

        // Write rs=1 rw=1 A5, bridge returns 5C
        ret_byte = 8'h5C;
        send(1'b1, 1'b1, 8'hA5);
        chk("accept_busy", 32'(busy), 1);
        chk("accept_ready", 32'(cmd_ready), 0);
        chk("accept_cs", 32'(cs), 0);
        wait_frames(1, 400);
        chk("wr_frame", 32'(last_frame), 32'h03A5);
        chk("wr_rises", 32'(last_rises), 16);
        chk("wr_cs_len", 32'(last_cs_len), CS_LEN);
        chk("wr_rv_at_rise", 32'(rv_at_rise), 1);
        chk("wr_rd_at_rise", 32'(rd_at_rise), 32'h5C);
        chk("wr_rsp_data", 32'(rsp_data), 32'h5C);
        chk("gap_busy", 32'(busy), 1);
        chk("gap_ready", 32'(cmd_ready), 0);
        repeat (2) @(negedge clk);
        chk("rv_single_pulse", 32'(rv_cnt), 1);

        // Read rs=0 rw=0, then dummy write collects the read byte
        ret_byte = 8'h11;
        send(1'b0, 1'b0, 8'h7E);
        wait_frames(1, 400);
        chk("rd_frame", 32'(last_frame), 32'h007E);
        chk("rd_rsp", 32'(rd_at_rise), 32'h11);
        ret_byte = 8'hC3;
        send(1'b0, 1'b1, 8'h00);
        wait_frames(1, 400);
        chk("dummy_frame", 32'(last_frame), 32'h0100);
        chk("dummy_rsp", 32'(rsp_data), 32'hC3);
        chk("dummy_rises", 32'(last_rises), 16);

        // Back-to-back with cmd_valid held high
        ret_byte  = 8'h96;
        cmd_rs    = 1'b1;
        cmd_rw    = 1'b1;
        cmd_data  = 8'h3C;
        cmd_valid = 1'b1;
        wait_frames(2, 800);
        cmd_valid = 1'b0;
        chk("b2b_frame", 32'(last_frame), 32'h033C);
        chk("b2b_rsp", 32'(rd_at_rise), 32'h96);
        chk("b2b_gap_min", 32'(gap_len >= GAP), 1);
        chk("b2b_gap_max", 32'(gap_len <= GAP + 2), 1);
        chk("ready_low_while_busy", 32'(busy_ready), 0);
        repeat (2) @(negedge clk);
        chk("rv_count_b2b", 32'(rv_cnt), 5);

        // Reset mid-HI while mosi is high
        ret_byte = 8'h00;
        send(1'b1, 1'b1, 8'hFF);
        for (int i = 0; i < 200 && !(sck && mosi && !cs); i++) @(negedge clk);
        chk("found_mid_hi", 32'(sck && mosi && !cs), 1);
        chk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cs", 32'(cs), 1);
        chk("abort_sck", 32'(sck), 0);
        chk("abort_mosi", 32'(mosi), 0);
        chk("abort_rsp_valid", 32'(rsp_valid), 0);
        chk("abort_rsp_data", 32'(rsp_data), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ready", 32'(cmd_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ready_after", 32'(cmd_ready), 1);
        @(negedge clk);
        chk_en = 1'b1;

        // Recovery frame after the abort
        ret_byte = 8'hA7;
        send(1'b0, 1'b1, 8'h42);
        wait_frames(1, 400);
        chk("rec_frame", 32'(last_frame), 32'h0142);
        chk("rec_rises", 32'(last_rises), 16);
        chk("rec_cs_len", 32'(last_cs_len), CS_LEN);
        chk("rec_rsp", 32'(rsp_data), 32'hA7);
        repeat (2) @(negedge clk);
        chk("rv_count_final", 32'(rv_cnt), 6);
        chk("ready_low_while_busy_final", 32'(busy_ready), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
